ec_point_arith: RTL and testbench
=================================

Name: ec_point_arith

Overview:
- Sequential point-arithmetic unit for a binary elliptic curve over GF(2^3): y^2 + x·y = x^3 + a·x^2 + b, with a = 101 and b = 001.
- Performs point doubling (2·P0) or point addition (P0 + P1) on projective inputs.
- Returns the result normalised to Z = 1, or the point-at-infinity encoding.
- Serves as the step engine of the point-generation / scalar-multiplication loop, which iterates P, 2P, 3P, ...

Parameters:
- M, 3, field width in bits; all coordinate ports are M bits wide.
- POLY, 3'b011, low bits of the reduction polynomial (x^3 + x + 1).
- CURVE_A, 3'b101, curve coefficient a (α^6).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; operands and op are sampled when start=1 and busy=0.
- op  in  1  0 = double P0; 1 = add P0 + P1.
- x0, y0, z0  in  M  operand P0, homogeneous projective (x = X/Z, y = Y/Z).
- x1, y1, z1  in  M  operand P1; ignored when op=0.
- x2, y2, z2  out  M  registered result.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; x2/y2/z2 are valid from that cycle onward.

Behaviour:
- Reset (asynchronous, rst_n low): x2 = y2 = z2 = 0, busy = 0, done = 0, FSM in IDLE. Reset asserted mid-operation aborts it; no done is produced.
- FSM states and transitions:
  - IDLE → CALC on an accepted start.
  - CALC → NORM after a fixed step count.
  - NORM → FIN.
  - FIN pulses done and returns to IDLE.
- start while busy=1 is ignored. The operands are captured internally, so input changes during busy have no effect.
- Latency from accepted start to done is a fixed constant, at most 40 cycles. It is identical for both ops and for every operand value: the unit is constant-time, with no data-dependent early exit.
- Field arithmetic:
  - Addition is XOR.
  - Multiplication is polynomial multiply reduced by x^3 + x + 1.
  - Inversion is z^6; one shared multiplier plus a squarer is sufficient.
  - Element encoding: α = 010, α^2 = 100, α^3 = 011, α^4 = 110, α^5 = 111, α^6 = 101.
- Point at infinity: any input with Z = 0. The output encoding is (000, 001, 000).
- Doubling, with x, y taken from P0 after normalisation:
  - If P0 = ∞, or x = 0, the result is ∞.
  - Otherwise λ = x + y/x; x' = λ^2 + λ + a; y' = x^2 + (λ+1)·x'.
- Addition:
  - P0 = ∞ → result is P1. P1 = ∞ → result is P0.
  - x0 = x1 and y0 = y1 → result equals doubling of P0.
  - x0 = x1 and y0 ≠ y1 (that is, P1 = −P0) → result is ∞.
  - Otherwise λ = (y0+y1)/(x0+x1); x' = λ^2 + λ + x0 + x1 + a; y' = λ·(x0 + x') + x' + y0.
- Output: finite results are always affine with z2 = 001. Outputs hold their value until the next done or reset.
- Inputs are not checked for curve membership; off-curve operands give a defined but unspecified finite/∞ result and never hang the FSM.

Test Plan:
- Reset check: with rst_n low, outputs read 0. Release reset, start op=0 with P0 = (110, 001, 001) → done after fixed latency, result (111, 011, 001).
- Projective input: op=0, P0 = (111, 010, 010) → (111, 011, 001). Same latency as the previous case.
- Add P + 2P: op=1, P0 = (110, 001, 001), P1 = (111, 011, 001) → (010, 000, 001).
- Inverse and infinity cases:
  - op=1, P0 = (110, 001, 001), P1 = (110, 111, 001) → (000, 001, 000).
  - op=1, P0 = ∞ (000, 001, 000), P1 = (111, 011, 001) → (111, 011, 001).
  - op=0, P0 = (000, 001, 001) → (000, 001, 000).
- Equal operands on add: op=1, P0 = P1 = (110, 001, 001) → (111, 011, 001).
- Handshake:
  - start pulsed again while busy, with different operands → ignored; exactly one done with the original result.
  - rst_n pulsed low mid-CALC → outputs return to 0, no done; a fresh start afterward works.
  - Iterative loop of 14 steps from P (double, then repeated add P) → all results on the curve, and the same fixed latency for every step.

Source files
------------

// File: rtl/ec_point_arith.sv
// Point double/add on y^2 + x*y = x^3 + a*x^2 + b over GF(2^M), poly x^M + POLY, b = 1.
// Latency: fixed 10 cycles from accepted start to done, for both ops and all operand values.
// Backpressure: none; start is ignored while busy and operands are captured on accept.
// Ports: clk, rst_n (async, active low); start/op request; x0..z0 and x1..z1 projective operands;
//        x2/y2/z2 registered result (affine, or infinity as (0,1,0)); busy; done (one-cycle pulse).
module ec_point_arith #(
  parameter int unsigned  M       = 3,
  parameter logic [M-1:0] POLY    = 3'b011,
  parameter logic [M-1:0] CURVE_A = 3'b101
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op,
  input  logic [M-1:0] x0,
  input  logic [M-1:0] y0,
  input  logic [M-1:0] z0,
  input  logic [M-1:0] x1,
  input  logic [M-1:0] y1,
  input  logic [M-1:0] z1,
  output logic [M-1:0] x2,
  output logic [M-1:0] y2,
  output logic [M-1:0] z2,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, CALC, NORM, FIN} state_t;

  localparam logic [3:0]   LAST_STEP = 4'd8;
  localparam logic [M-1:0] ZERO      = '0;
  localparam logic [M-1:0] ONE       = {{(M-1){1'b0}}, 1'b1};

  // Shift-and-add multiply with on-the-fly reduction.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] acc;
    logic [M-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[M-1] ? ({sh[M-2:0], 1'b0} ^ POLY) : {sh[M-2:0], 1'b0};
    end
    return acc;
  endfunction

  function automatic logic [M-1:0] gf_sq(input logic [M-1:0] a);
    return gf_mul(a, a);
  endfunction

  state_t       state_q, state_d;
  logic [3:0]   step_q, step_d;
  logic         op_q, op_d;
  logic [M-1:0] cx0_q, cx0_d, cy0_q, cy0_d, cz0_q, cz0_d;
  logic [M-1:0] cx1_q, cx1_d, cy1_q, cy1_d, cz1_q, cz1_d;
  logic [M-1:0] inv_q, inv_d;
  logic [M-1:0] ax0_q, ax0_d, ay0_q, ay0_d, ax1_q, ax1_d, ay1_q, ay1_d;
  logic [M-1:0] lam_q, lam_d, xr_q, xr_d, yr_q, yr_d;
  logic [M-1:0] x2_q, x2_d, y2_q, y2_d, z2_q, z2_d;
  logic         busy_q, busy_d, done_q, done_d;

  logic         dbl, inf0, inf1;
  logic [M-1:0] den, num, xr_c;
  logic [M-1:0] mul_a, mul_b, mul_r;

  assign inf0 = (cz0_q == ZERO);
  assign inf1 = (cz1_q == ZERO);

  // Adding a point to itself takes the tangent (doubling) slope.
  assign dbl  = !op_q || ((ax0_q == ax1_q) && (ay0_q == ay1_q));
  // Doubling slope x + y/x is folded into (x^2 + y)/x so both ops share one divide.
  assign den  = dbl ? ax0_q : (ax0_q ^ ax1_q);
  assign num  = dbl ? (gf_sq(ax0_q) ^ ay0_q) : (ay0_q ^ ay1_q);
  assign xr_c = gf_sq(lam_q) ^ lam_q ^ CURVE_A ^ (dbl ? ZERO : (ax0_q ^ ax1_q));

  assign mul_r = gf_mul(mul_a, mul_b);

  // Single shared multiplier; one product per CALC step. Inverse is z^6 = (z^2 * z)^2.
  always_comb begin
    mul_a = ZERO;
    mul_b = ZERO;
    case (step_q)
      4'd0: begin mul_a = gf_sq(cz0_q); mul_b = cz0_q; end
      4'd1: begin mul_a = cx0_q;        mul_b = inv_q; end
      4'd2: begin mul_a = cy0_q;        mul_b = inv_q; end
      4'd3: begin mul_a = gf_sq(cz1_q); mul_b = cz1_q; end
      4'd4: begin mul_a = cx1_q;        mul_b = inv_q; end
      4'd5: begin mul_a = cy1_q;        mul_b = inv_q; end
      4'd6: begin mul_a = gf_sq(den);   mul_b = den;   end
      4'd7: begin mul_a = num;          mul_b = inv_q; end
      4'd8: begin
        mul_a = dbl ? (lam_q ^ ONE) : lam_q;
        mul_b = dbl ? xr_c : (ax0_q ^ xr_c);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    op_d    = op_q;
    cx0_d   = cx0_q;  cy0_d = cy0_q;  cz0_d = cz0_q;
    cx1_d   = cx1_q;  cy1_d = cy1_q;  cz1_d = cz1_q;
    inv_d   = inv_q;
    ax0_d   = ax0_q;  ay0_d = ay0_q;  ax1_d = ax1_q;  ay1_d = ay1_q;
    lam_d   = lam_q;  xr_d  = xr_q;   yr_d  = yr_q;
    x2_d    = x2_q;   y2_d  = y2_q;   z2_d  = z2_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          cx0_d   = x0;  cy0_d = y0;  cz0_d = z0;
          cx1_d   = x1;  cy1_d = y1;  cz1_d = z1;
          step_d  = 4'd0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      // Every step runs regardless of op or operand values: constant time.
      CALC: begin
        step_d = step_q + 4'd1;
        case (step_q)
          4'd0, 4'd3, 4'd6: inv_d = gf_sq(mul_r);
          4'd1: ax0_d = mul_r;
          4'd2: ay0_d = mul_r;
          4'd4: ax1_d = mul_r;
          4'd5: ay1_d = mul_r;
          4'd7: lam_d = mul_r;
          4'd8: begin
            xr_d = xr_c;
            yr_d = dbl ? (gf_sq(ax0_q) ^ mul_r) : (mul_r ^ xr_c ^ ay0_q);
          end
          default: ;
        endcase
        if (step_q == LAST_STEP) state_d = NORM;
      end
      // Special-case selection; defaults to the infinity encoding.
      NORM: begin
        x2_d = ZERO;
        y2_d = ONE;
        z2_d = ZERO;
        if (!op_q) begin
          if (!inf0 && (ax0_q != ZERO)) begin
            x2_d = xr_q; y2_d = yr_q; z2_d = ONE;
          end
        end else if (inf0) begin
          if (!inf1) begin
            x2_d = ax1_q; y2_d = ay1_q; z2_d = ONE;
          end
        end else if (inf1) begin
          x2_d = ax0_q; y2_d = ay0_q; z2_d = ONE;
        end else if ((ax0_q != ax1_q) || ((ay0_q == ay1_q) && (ax0_q != ZERO))) begin
          x2_d = xr_q; y2_d = yr_q; z2_d = ONE;
        end
        done_d  = 1'b1;
        state_d = FIN;
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= 4'd0;
      op_q    <= 1'b0;
      cx0_q   <= '0;  cy0_q <= '0;  cz0_q <= '0;
      cx1_q   <= '0;  cy1_q <= '0;  cz1_q <= '0;
      inv_q   <= '0;
      ax0_q   <= '0;  ay0_q <= '0;  ax1_q <= '0;  ay1_q <= '0;
      lam_q   <= '0;  xr_q  <= '0;  yr_q  <= '0;
      x2_q    <= '0;  y2_q  <= '0;  z2_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      op_q    <= op_d;
      cx0_q   <= cx0_d;  cy0_q <= cy0_d;  cz0_q <= cz0_d;
      cx1_q   <= cx1_d;  cy1_q <= cy1_d;  cz1_q <= cz1_d;
      inv_q   <= inv_d;
      ax0_q   <= ax0_d;  ay0_q <= ay0_d;  ax1_q <= ax1_d;  ay1_q <= ay1_d;
      lam_q   <= lam_d;  xr_q  <= xr_d;   yr_q  <= yr_d;
      x2_q    <= x2_d;   y2_q  <= y2_d;   z2_q  <= z2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x2   = x2_q;
  assign y2   = y2_q;
  assign z2   = z2_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_ec_point_arith.sv
module tb_ec_point_arith;

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
    logic [2:0] z;
  } pt_t;

  localparam logic [2:0] A   = 3'b101;
  localparam pt_t        INF = '{x: 3'b000, y: 3'b001, z: 3'b000};

  logic       clk, rst_n, start, op;
  logic [2:0] x0, y0, z0, x1, y1, z1;
  logic [2:0] x2, y2, z2;
  logic       busy, done;

  int  checks   = 0;
  int  failures = 0;
  int  lat_ref  = -1;
  pt_t curve_pts[$];

  ec_point_arith dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .x0(x0), .y0(y0), .z0(z0), .x1(x1), .y1(y1), .z1(z1),
    .x2(x2), .y2(y2), .z2(z2), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model: plain GF(8) arithmetic ----------------
  function automatic logic [2:0] fmul(input logic [2:0] a, input logic [2:0] b);
    logic [5:0] p;
    p = '0;
    for (int i = 0; i < 3; i++)
      if (b[i]) p = p ^ (6'(a) << i);
    if (p[4]) p = p ^ 6'b010110;
    if (p[3]) p = p ^ 6'b001011;
    return p[2:0];
  endfunction

  function automatic logic [2:0] finv(input logic [2:0] a);
    for (int b = 1; b < 8; b++)
      if (fmul(a, 3'(b)) == 3'b001) return 3'(b);
    return 3'b000;
  endfunction

  function automatic bit on_curve(input logic [2:0] x, input logic [2:0] y);
    logic [2:0] x2v;
    x2v = fmul(x, x);
    return (fmul(y, y) ^ fmul(x, y)) == (fmul(x2v, x) ^ fmul(A, x2v) ^ 3'b001);
  endfunction

  function automatic pt_t ref_dbl(input bit fin, input logic [2:0] x, input logic [2:0] y);
    logic [2:0] lam, xn, yn;
    if (!fin || x == 3'b000) return INF;
    lam = x ^ fmul(y, finv(x));
    xn  = fmul(lam, lam) ^ lam ^ A;
    yn  = fmul(x, x) ^ fmul(lam ^ 3'b001, xn);
    return '{x: xn, y: yn, z: 3'b001};
  endfunction

  function automatic pt_t ref_op(input logic opv, input pt_t p0, input pt_t p1);
    bit         fin0, fin1;
    logic [2:0] ax0, ay0, ax1, ay1, lam, xn, yn;
    fin0 = (p0.z != 3'b000);
    fin1 = (p1.z != 3'b000);
    ax0  = fmul(p0.x, finv(p0.z));
    ay0  = fmul(p0.y, finv(p0.z));
    ax1  = fmul(p1.x, finv(p1.z));
    ay1  = fmul(p1.y, finv(p1.z));
    if (!opv) return ref_dbl(fin0, ax0, ay0);
    if (!fin0) return fin1 ? '{x: ax1, y: ay1, z: 3'b001} : INF;
    if (!fin1) return '{x: ax0, y: ay0, z: 3'b001};
    if (ax0 == ax1) return (ay0 == ay1) ? ref_dbl(1'b1, ax0, ay0) : INF;
    lam = fmul(ay0 ^ ay1, finv(ax0 ^ ax1));
    xn  = fmul(lam, lam) ^ lam ^ ax0 ^ ax1 ^ A;
    yn  = fmul(lam, ax0 ^ xn) ^ xn ^ ay0;
    return '{x: xn, y: yn, z: 3'b001};
  endfunction

  // Random projective representation of an affine point (or random-junk infinity).
  function automatic pt_t rand_proj(input pt_t p);
    logic [2:0] z;
    if (p.z == 3'b000) return '{x: 3'($urandom), y: 3'($urandom), z: 3'b000};
    z = 3'($urandom_range(7, 1));
    return '{x: fmul(p.x, z), y: fmul(p.y, z), z: z};
  endfunction

  // ---------------- stimulus ----------------
  task automatic scramble_inputs();
    op = 1'($urandom);
    x0 = 3'($urandom); y0 = 3'($urandom); z0 = 3'($urandom);
    x1 = 3'($urandom); y1 = 3'($urandom); z1 = 3'($urandom);
  endtask

  // Issue one request, scramble inputs while busy, wait (bounded) for done.
  task automatic run_op(input logic opv, input pt_t a, input pt_t b,
                        output pt_t res, output int lat, output bit got);
    @(negedge clk);
    start = 1'b1; op = opv;
    {x0, y0, z0} = a;
    {x1, y1, z1} = b;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      scramble_inputs();
      if (done) got = 1'b1;
    end
    res = {x2, y2, z2};
  endtask

  task automatic test_reset();
    pt_t res; int lat; bit got;
    rst_n = 1'b0; start = 1'b0; op = 1'b0;
    {x0, y0, z0, x1, y1, z1} = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({x2, y2, z2} !== 9'b0) begin
      failures++; $display("FAIL reset_xyz got=%b exp=%b", {x2, y2, z2}, 9'b0);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_flags got busy=%b done=%b exp 0 0", busy, done);
    end
    rst_n = 1'b1;
    run_op(1'b0, '{3'b110, 3'b001, 3'b001}, '0, res, lat, got);
    checks++;
    if (!got) begin failures++; $display("FAIL first_done timeout after %0d cycles", lat); end
    checks++;
    if (res !== pt_t'({3'b111, 3'b011, 3'b001})) begin
      failures++; $display("FAIL first_double got=%b exp=%b", res, 9'b111011001);
    end
    checks++;
    if (lat < 1 || lat > 40) begin
      failures++; $display("FAIL first_latency got=%0d exp 1..40", lat);
    end
    lat_ref = lat;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL done_pulse got done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_vectors();
    logic vop[6];
    pt_t  vp0[6], vp1[6], vexp[6];
    pt_t  res; int lat; bit got;
    vop[0] = 1'b0; vp0[0] = '{3'b111, 3'b010, 3'b010}; vp1[0] = '0;                       vexp[0] = '{3'b111, 3'b011, 3'b001};
    vop[1] = 1'b1; vp0[1] = '{3'b110, 3'b001, 3'b001}; vp1[1] = '{3'b111, 3'b011, 3'b001}; vexp[1] = '{3'b010, 3'b000, 3'b001};
    vop[2] = 1'b1; vp0[2] = '{3'b110, 3'b001, 3'b001}; vp1[2] = '{3'b110, 3'b111, 3'b001}; vexp[2] = INF;
    vop[3] = 1'b1; vp0[3] = INF;                       vp1[3] = '{3'b111, 3'b011, 3'b001}; vexp[3] = '{3'b111, 3'b011, 3'b001};
    vop[4] = 1'b0; vp0[4] = '{3'b000, 3'b001, 3'b001}; vp1[4] = '0;                       vexp[4] = INF;
    vop[5] = 1'b1; vp0[5] = '{3'b110, 3'b001, 3'b001}; vp1[5] = '{3'b110, 3'b001, 3'b001}; vexp[5] = '{3'b111, 3'b011, 3'b001};
    for (int i = 0; i < 6; i++) begin
      run_op(vop[i], vp0[i], vp1[i], res, lat, got);
      checks++;
      if (!got) begin failures++; $display("FAIL vec%0d_done timeout", i); end
      checks++;
      if (res !== vexp[i]) begin
        failures++; $display("FAIL vec%0d_result got=%b exp=%b", i, res, vexp[i]);
      end
      checks++;
      if (lat !== lat_ref) begin
        failures++; $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, lat_ref);
      end
    end
  endtask

  task automatic test_random();
    pt_t a, b, exp, res; int lat; bit got; logic opv;
    for (int i = 0; i < 40; i++) begin
      opv = 1'($urandom);
      a   = rand_proj(curve_pts[$urandom_range(curve_pts.size() - 1, 0)]);
      b   = rand_proj(curve_pts[$urandom_range(curve_pts.size() - 1, 0)]);
      exp = ref_op(opv, a, b);
      run_op(opv, a, b, res, lat, got);
      checks++;
      if (!got || res !== exp) begin
        failures++;
        $display("FAIL rand%0d op=%b p0=%b p1=%b got=%b exp=%b done=%b", i, opv, a, b, res, exp, got);
      end
      checks++;
      if (lat !== lat_ref) begin
        failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", i, lat, lat_ref);
      end
    end
  endtask

  task automatic test_back_to_back_start();
    pt_t res; int dones;
    @(negedge clk);
    start = 1'b1; op = 1'b0;
    {x0, y0, z0} = {3'b111, 3'b010, 3'b010};
    {x1, y1, z1} = '0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_high got=%b exp=1", busy); end
    start = 1'b1; op = 1'b1;
    {x0, y0, z0} = {3'b110, 3'b001, 3'b001};
    {x1, y1, z1} = {3'b111, 3'b011, 3'b001};
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    res   = '0;
    repeat (30) begin
      @(negedge clk);
      if (done) begin dones++; res = {x2, y2, z2}; end
    end
    checks++;
    if (dones !== 1) begin failures++; $display("FAIL busy_start_dones got=%0d exp=1", dones); end
    checks++;
    if (res !== pt_t'({3'b111, 3'b011, 3'b001})) begin
      failures++; $display("FAIL busy_start_result got=%b exp=%b", res, 9'b111011001);
    end
  endtask

  task automatic test_reset_mid();
    pt_t res, exp; int lat; bit got; int dones;
    @(negedge clk);
    start = 1'b1; op = 1'b0;
    {x0, y0, z0} = {3'b111, 3'b010, 3'b010};
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({x2, y2, z2} !== 9'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state got xyz=%b busy=%b done=%b exp 0", {x2, y2, z2}, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones !== 0) begin failures++; $display("FAIL midreset_no_done got=%0d exp=0", dones); end
    exp = ref_op(1'b1, '{3'b110, 3'b001, 3'b001}, '{3'b111, 3'b011, 3'b001});
    run_op(1'b1, '{3'b110, 3'b001, 3'b001}, '{3'b111, 3'b011, 3'b001}, res, lat, got);
    checks++;
    if (!got || res !== exp) begin
      failures++; $display("FAIL midreset_restart got=%b exp=%b done=%b", res, exp, got);
    end
    checks++;
    if (lat !== lat_ref) begin
      failures++; $display("FAIL midreset_latency got=%0d exp=%0d", lat, lat_ref);
    end
  endtask

  task automatic test_loop();
    pt_t p, q, exp, res; int lat; bit got; logic opv;
    p = '{3'b110, 3'b001, 3'b001};
    q = p;
    for (int s = 0; s < 14; s++) begin
      opv = (s == 0) ? 1'b0 : 1'b1;
      exp = ref_op(opv, q, p);
      run_op(opv, q, p, res, lat, got);
      checks++;
      if (!got || res !== exp) begin
        failures++; $display("FAIL loop%0d got=%b exp=%b done=%b", s, res, exp, got);
      end
      checks++;
      if (!(res == INF || (res.z == 3'b001 && on_curve(res.x, res.y)))) begin
        failures++; $display("FAIL loop%0d_on_curve got=%b exp on-curve or %b", s, res, INF);
      end
      checks++;
      if (lat !== lat_ref) begin
        failures++; $display("FAIL loop%0d_latency got=%0d exp=%0d", s, lat, lat_ref);
      end
      q = exp;
    end
  endtask

  initial begin
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        if (on_curve(3'(x), 3'(y))) curve_pts.push_back('{x: 3'(x), y: 3'(y), z: 3'b001});
    curve_pts.push_back(INF);

    test_reset();
    test_vectors();
    test_random();
    test_back_to_back_start();
    test_reset_mid();
    test_loop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
